// File: rtl/aud_pkg.sv
// Shared definitions for the AUD branch-trace capture block: state encodings,
// default sizes and the drop-counter helper.
package aud_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int DROP_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_TRIG  = 2'd2,
        ST_DONE  = 2'd3
    } aud_state_e;

    // Saturating increment so a long overflow burst never wraps back to a small count.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + {{(DROP_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/aud_trace_fifo.sv
// Trace buffer: first-word-fall-through FIFO with optional overwrite-oldest
// behaviour when a push arrives on a full buffer. DEPTH must be a power of two >= 2.
module aud_trace_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    input  logic         i_overwrite,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [W-1:0]  r_mem [DEPTH];

    logic w_do_pop;
    logic w_do_push;
    logic w_evict;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees a slot, so a full buffer still accepts the push.
    assign w_do_push = i_push & (~o_full | w_do_pop | i_overwrite);
    assign w_evict   = i_push & o_full & ~w_do_pop & i_overwrite;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop || w_evict) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !(w_do_pop || w_evict)) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/aud_trace_ctrl.sv
// Branch-trace capture controller: arms on host command, captures addresses from
// aud_btm into a circular pre-trigger buffer, triggers on a masked compare, then
// captures a fixed number of post-trigger entries.
module aud_trace_ctrl
    import aud_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              aud_ck,
    input  logic              rst,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              addr_valid,
    input  logic              buserror,
    output logic              btm_oe,
    input  logic              cmd_arm,
    input  logic              cmd_stop,
    input  logic [ADDR_W-1:0] trig_addr,
    input  logic [ADDR_W-1:0] trig_mask,
    input  logic [7:0]        post_count,
    output logic [ADDR_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [1:0]        state,
    output logic              done,
    output logic              err,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    // Reset asserts immediately but releases two aud_ck edges later.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge aud_ck or negedge rst) begin
        if (!rst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    aud_state_e        r_state;
    logic              r_btm_oe;
    logic              r_err;
    logic              r_ovf;
    logic [DROP_W-1:0] r_drop_cnt;
    logic [7:0]        r_post_cnt;

    aud_state_e        w_next_state;
    logic              w_next_err;
    logic              w_next_ovf;
    logic [DROP_W-1:0] w_next_drop;
    logic [7:0]        w_next_post;
    logic              w_next_oe;

    logic              w_cap;
    logic              w_match;
    logic              w_drop;
    logic              w_pop;
    logic              w_flush;
    logic              w_full;
    logic              w_empty;

    // No captures once the post-trigger window is exhausted or a command/error is pending.
    assign w_cap   = addr_valid & r_btm_oe & ~cmd_stop & ~cmd_arm & ~buserror &
                     ~((r_state == ST_TRIG) && (r_post_cnt == 8'd0));
    assign w_match = (((br_addr ^ trig_addr) & trig_mask) == '0);
    assign w_pop   = ~w_empty & rd_ready;
    assign w_drop  = w_cap & (r_state == ST_TRIG) & w_full & ~w_pop;
    assign w_flush = cmd_arm & ~cmd_stop;

    aud_trace_fifo #(
        .W     (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (aud_ck),
        .i_rst_n     (w_rst_n),
        .i_flush     (w_flush),
        .i_push      (w_cap),
        .i_din       (br_addr),
        .i_pop       (w_pop),
        .i_overwrite (r_state == ST_ARMED),
        .o_head      (rd_data),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_err   = r_err;
        w_next_ovf   = r_ovf;
        w_next_drop  = r_drop_cnt;
        w_next_post  = r_post_cnt;

        if (cmd_stop) begin
            w_next_state = ST_DONE;
        end else if (cmd_arm) begin
            w_next_state = ST_ARMED;
            w_next_err   = 1'b0;
            w_next_ovf   = 1'b0;
            w_next_drop  = '0;
            w_next_post  = 8'd0;
        end else if (buserror && (r_state == ST_ARMED || r_state == ST_TRIG)) begin
            w_next_err   = 1'b1;
            w_next_state = ST_DONE;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (w_cap && w_match) begin
                        w_next_state = ST_TRIG;
                        w_next_post  = post_count;
                    end
                end
                ST_TRIG: begin
                    if (r_post_cnt == 8'd0) begin
                        w_next_state = ST_DONE;
                    end else if (w_cap) begin
                        w_next_post = r_post_cnt - 8'd1;
                        if (r_post_cnt == 8'd1) begin
                            w_next_state = ST_DONE;
                        end
                        if (w_drop) begin
                            w_next_ovf  = 1'b1;
                            w_next_drop = sat_inc(r_drop_cnt);
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        w_next_oe = ((w_next_state == ST_ARMED) || (w_next_state == ST_TRIG)) && !w_next_err;
    end

    always_ff @(posedge aud_ck or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= ST_IDLE;
            r_btm_oe   <= 1'b0;
            r_err      <= 1'b0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
            r_post_cnt <= 8'd0;
        end else begin
            r_state    <= w_next_state;
            r_btm_oe   <= w_next_oe;
            r_err      <= w_next_err;
            r_ovf      <= w_next_ovf;
            r_drop_cnt <= w_next_drop;
            r_post_cnt <= w_next_post;
        end
    end

    assign btm_oe   = r_btm_oe;
    assign rd_valid = ~w_empty;
    assign state    = r_state;
    assign done     = (r_state == ST_DONE);
    assign err      = r_err;
    assign overflow = r_ovf;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_aud_trace_ctrl.sv
// Directed bench for aud_trace_ctrl: a small behavioural model tracks state and
// flags while expected FIFO contents are queued at capture and checked on readout.
module tb_aud_trace_ctrl;

    localparam int AW    = 32;
    localparam int DEPTH = 16;

    logic          aud_ck = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] br_addr = '0;
    logic          addr_valid = 1'b0;
    logic          buserror = 1'b0;
    logic          btm_oe;
    logic          cmd_arm = 1'b0;
    logic          cmd_stop = 1'b0;
    logic [AW-1:0] trig_addr = '0;
    logic [AW-1:0] trig_mask = '0;
    logic [7:0]    post_count = '0;
    logic [AW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [1:0]    state;
    logic          done;
    logic          err;
    logic          overflow;
    logic [15:0]   drop_cnt;

    aud_trace_ctrl #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .aud_ck     (aud_ck),
        .rst        (rst),
        .br_addr    (br_addr),
        .addr_valid (addr_valid),
        .buserror   (buserror),
        .btm_oe     (btm_oe),
        .cmd_arm    (cmd_arm),
        .cmd_stop   (cmd_stop),
        .trig_addr  (trig_addr),
        .trig_mask  (trig_mask),
        .post_count (post_count),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .state      (state),
        .done       (done),
        .err        (err),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 aud_ck = ~aud_ck;

    int total = 0;
    int bad = 0;
    logic [AW-1:0] exp_q[$];

    logic [1:0]  m_state = 2'd0;
    logic [7:0]  m_post  = 8'd0;
    logic        m_ovf   = 1'b0;
    logic        m_err   = 1'b0;
    logic [15:0] m_drop  = 16'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aud_ck);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_state"}, {30'd0, state}, {30'd0, m_state});
        check({tag, "_done"}, {31'd0, done}, {31'd0, m_state == 2'd3});
        check({tag, "_err"}, {31'd0, err}, {31'd0, m_err});
        check({tag, "_oe"}, {31'd0, btm_oe}, {31'd0, (m_state == 2'd1 || m_state == 2'd2) && !m_err});
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
        check({tag, "_drop"}, {16'd0, drop_cnt}, {16'd0, m_drop});
    endtask

    task automatic arm();
        cmd_arm = 1'b1;
        tick();
        cmd_arm = 1'b0;
        exp_q.delete();
        m_state = 2'd1;
        m_post  = 8'd0;
        m_ovf   = 1'b0;
        m_err   = 1'b0;
        m_drop  = 16'd0;
    endtask

    task automatic capture(input logic [AW-1:0] a);
        br_addr    = a;
        addr_valid = 1'b1;
        if (m_state == 2'd2 && m_post == 8'd0) begin
            m_state = 2'd3;
        end else if (m_state == 2'd1) begin
            if (exp_q.size() == DEPTH) void'(exp_q.pop_front());
            exp_q.push_back(a);
            if ((a & trig_mask) == (trig_addr & trig_mask)) begin
                m_state = 2'd2;
                m_post  = post_count;
            end
        end else if (m_state == 2'd2) begin
            if (exp_q.size() == DEPTH) begin
                m_ovf  = 1'b1;
                m_drop = m_drop + 16'd1;
            end else begin
                exp_q.push_back(a);
            end
            m_post = m_post - 8'd1;
            if (m_post == 8'd0) m_state = 2'd3;
        end
        tick();
        addr_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            check({tag, "_rv"}, {31'd0, rd_valid}, 32'd1);
            check({tag, "_rd"}, rd_data, exp_q[0]);
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
            void'(exp_q.pop_front());
        end
        check({tag, "_empty"}, {31'd0, rd_valid}, 32'd0);
    endtask

    initial begin
        // Reset values while rst is held low.
        #2;
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_oe", {31'd0, btm_oe}, 32'd0);
        check("rst_rv", {31'd0, rd_valid}, 32'd0);
        check("rst_rd", rd_data, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_drop", {16'd0, drop_cnt}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        tick();
        check_status("post_rst");

        // buserror outside a capture window has no effect.
        buserror = 1'b1;
        tick();
        buserror = 1'b0;
        check_status("idle_buserr");

        // Basic trigger with one post-trigger capture.
        trig_addr  = 32'h2;
        trig_mask  = 32'hFFFF_FFFF;
        post_count = 8'd1;
        arm();
        check_status("t1_arm");
        capture(32'h1);
        check_status("t1_c1");
        check("t1_lat_rv", {31'd0, rd_valid}, 32'd1);
        check("t1_lat_rd", rd_data, 32'h1);
        capture(32'h2);
        check_status("t1_c2");
        capture(32'h3);
        check_status("t1_c3");
        drain("t1");

        // Circular pre-trigger buffer keeps the newest 16 entries.
        trig_addr  = 32'd19;
        post_count = 8'd0;
        arm();
        for (int i = 0; i < 20; i++) capture(i[AW-1:0]);
        check_status("t2_trig");
        tick();
        m_state = 2'd3;
        check_status("t2_done");
        check("t2_head", rd_data, 32'd4);
        drain("t2");

        // Post-trigger overflow drops new entries and counts them.
        trig_addr  = 32'h10F;
        post_count = 8'd3;
        arm();
        for (int i = 0; i < 16; i++) capture(32'h100 + i);
        check_status("t3_full");
        for (int i = 0; i < 3; i++) capture(32'h200 + i);
        check_status("t3_ovf");
        drain("t3");

        // Simultaneous push and pop on a full buffer in TRIGGERED.
        trig_addr  = 32'h300;
        post_count = 8'd20;
        arm();
        for (int i = 0; i < 16; i++) capture(32'h300 + i);
        check_status("t4_full");
        check("t4_head", rd_data, exp_q[0]);
        br_addr    = 32'h310;
        addr_valid = 1'b1;
        rd_ready   = 1'b1;
        void'(exp_q.pop_front());
        exp_q.push_back(32'h310);
        m_post = m_post - 8'd1;
        tick();
        addr_valid = 1'b0;
        rd_ready   = 1'b0;
        check_status("t4_both");
        drain("t4");
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        m_state = 2'd3;
        check_status("t4_stop");
        capture(32'h999);
        check("t4_done_ignored", {31'd0, rd_valid}, 32'd0);

        // Bus error ends the session; stop beats arm; buffer stays readable.
        trig_addr  = 32'hFFFF_FFFF;
        post_count = 8'd0;
        arm();
        capture(32'h400);
        buserror = 1'b1;
        tick();
        buserror = 1'b0;
        m_err   = 1'b1;
        m_state = 2'd3;
        check_status("t5_err");
        cmd_arm  = 1'b1;
        cmd_stop = 1'b1;
        tick();
        cmd_arm  = 1'b0;
        cmd_stop = 1'b0;
        check_status("t5_stop_wins");
        drain("t5");
        arm();
        check_status("t5_rearm");

        // Masked compare with an immediate finish.
        trig_addr = 32'hA0;
        trig_mask = 32'hF0;
        capture(32'h5B);
        check_status("t6_nomatch");
        capture(32'hAB);
        check_status("t6_match");
        capture(32'h77);
        check_status("t6_done");
        drain("t6");

        // Asynchronous reset in the middle of a post-trigger window.
        trig_addr  = 32'h500;
        trig_mask  = 32'hFFFF_FFFF;
        post_count = 8'd10;
        arm();
        capture(32'h4FF);
        capture(32'h500);
        capture(32'h501);
        capture(32'h502);
        capture(32'h503);
        check_status("t7_pre");
        #2;
        rst = 1'b0;
        #1;
        check("t7_state", {30'd0, state}, 32'd0);
        check("t7_oe", {31'd0, btm_oe}, 32'd0);
        check("t7_rv", {31'd0, rd_valid}, 32'd0);
        check("t7_rd", rd_data, 32'd0);
        check("t7_done", {31'd0, done}, 32'd0);
        check("t7_err", {31'd0, err}, 32'd0);
        check("t7_ovf", {31'd0, overflow}, 32'd0);
        check("t7_drop", {16'd0, drop_cnt}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        tick();
        exp_q.delete();
        m_state = 2'd0;
        m_post  = 8'd0;
        m_ovf   = 1'b0;
        m_err   = 1'b0;
        m_drop  = 16'd0;
        check_status("t7_release");
        check("t7_empty", {31'd0, rd_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
